riscv_wb_arbiter: RTL
=====================

// Module: riscv_wb_arbiter
// PURPOSE
//  Parametrised writeback arbiter/buffer sitting between EX-stage result producers (ALU, MULT, LSU, CSR, ...)
//  and the register-file write port. Each source pushes results over valid/ready into a private FIFO.
//  A round-robin or fixed-priority arbiter drains one entry per cycle into a registered write port.
//  Replaces single-port contention stalls with buffering and reports contention.
// PARAMETERS
//  N_SRC       3   number of result sources (>=2)
//  DEPTH       2   entries per source FIFO (power of 2, >=2)
//  DATA_WIDTH  32  result width
//  ADDR_WIDTH  6   register-file write address width
//  RR_ARB      1   1: round-robin arbitration; 0: fixed priority, lowest index wins
// PORTS
//  clk           in   1                   clock, all state on rising edge
//  rst_n         in   1                   asynchronous active-low reset
//  flush_i       in   1                   synchronous flush of all buffered results
//  src_valid_i   in   N_SRC               per-source result valid
//  src_waddr_i   in   N_SRC*ADDR_WIDTH    per-source destination address, source i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//  src_wdata_i   in   N_SRC*DATA_WIDTH    per-source result data, same packing
//  src_ready_o   out  N_SRC               per-source FIFO not full
//  wb_we_o       out  1                   register-file write enable
//  wb_waddr_o    out  ADDR_WIDTH          register-file write address
//  wb_wdata_o    out  DATA_WIDTH          register-file write data
//  wb_src_o      out  $clog2(N_SRC)       index of source that produced current write
//  contention_o  out  1                   registered; >1 FIFO was non-empty at last arbitration
//  busy_o        out  1                   any FIFO non-empty or wb_we_o high
// BEHAVIOUR
//  Reset: all FIFOs empty, RR pointer = 0, wb_we_o/wb_waddr_o/wb_wdata_o/wb_src_o/contention_o = 0.
//   src_ready_o is all ones after reset (derived from empty FIFOs).
//  Push: src_valid_i[i] & src_ready_o[i] at edge k writes the entry into FIFO i.
//   src_ready_o[i] = (count_i < DEPTH); depends only on state, never on the same-cycle pop.
//   A full FIFO therefore refuses a push even in a cycle where it pops.
//  No bypass: an entry pushed at edge k is eligible for arbitration in cycle k+1.
//   It appears on wb_* after edge k+1 at the earliest; minimum latency is 2 edges.
//  Arbitration, once per cycle, over non-empty FIFOs:
//   Exactly one head is granted and popped. Its waddr/wdata/index are registered onto wb_*, and wb_we_o <= 1.
//   No FIFO non-empty: wb_we_o <= 0; wb_waddr_o/wb_wdata_o/wb_src_o hold their values.
//   RR_ARB=1: search starts at the RR pointer; on grant g, pointer <= (g+1) mod N_SRC; unchanged when idle.
//   RR_ARB=0: lowest-index non-empty FIFO wins; a source may starve (documented, intended).
//  The write port always accepts: one write per cycle, no backpressure from the register file.
//  Per-source order is FIFO-preserved. Cross-source WAW ordering is NOT enforced; producers must not
//   have two in-flight results to the same waddr from different sources.
//  Counters: each count is $clog2(DEPTH)+1 bits. Read/write pointers are $clog2(DEPTH) bits and wrap
//   naturally. Push and pop on a non-full, non-empty FIFO in the same cycle: count unchanged.
//  contention_o <= (number of non-empty FIFOs at arbitration > 1).
//  flush_i at edge k:
//   all counts/pointers <= 0; wb_we_o <= 0; contention_o <= 0; RR pointer unchanged.
//   Pushes in the same cycle are discarded. The entry already on wb_* (we=1) during the flush cycle
//    is still written (it was committed).
//  Reset asserted mid-operation: immediate asynchronous clear to reset state; buffered results are lost.
// TESTING
//  1 Single push src0 waddr=5 data=0xDEADBEEF, idle otherwise -> wb_we_o=1, waddr=5, data=0xDEADBEEF,
//    wb_src_o=0, exactly 2 edges after the push; wb_we_o=0 on the next cycle.
//  2 RR_ARB=1, N_SRC=3: all sources push 2 entries each in 2 consecutive cycles -> grant order
//    0,1,2,0,1,2; contention_o=1 during draining; busy_o falls after 6 writes.
//  3 Backpressure, DEPTH=2: src1 pushes every cycle while src0 is continuously non-empty, RR_ARB=0 ->
//    src_ready_o[1]=0 after 2 pushes; no src1 entry is lost or duplicated once src0 stops.
//  4 Full FIFO with a same-cycle pop -> push refused (ready=0), count goes DEPTH to DEPTH-1,
//    and ready=1 on the next cycle.
//  5 Flush with 2 entries buffered in each FIFO plus a same-cycle push -> no wb_we_o after the flush edge.
//    All src_ready_o=1; subsequent pushes drain normally.
//  6 Reset asserted asynchronously mid-drain -> all outputs 0 immediately (before the next clock edge);
//    src_ready_o all 1.

Source files
------------

// File: rtl/riscv_wb_arbiter_if.sv
// Source-to-writeback bundle: per-source result handshakes in, registered register-file write port out.
// Modport master is the producer/observer side, slave is the arbiter.
interface riscv_wb_arbiter_if #(
  parameter int N_SRC      = 3,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
);
  localparam int SW = $clog2(N_SRC);

  logic [N_SRC-1:0]            src_valid_i;
  logic [N_SRC*ADDR_WIDTH-1:0] src_waddr_i;
  logic [N_SRC*DATA_WIDTH-1:0] src_wdata_i;
  logic [N_SRC-1:0]            src_ready_o;
  logic                        wb_we_o;
  logic [ADDR_WIDTH-1:0]       wb_waddr_o;
  logic [DATA_WIDTH-1:0]       wb_wdata_o;
  logic [SW-1:0]               wb_src_o;
  logic                        contention_o;
  logic                        busy_o;

  modport master (
    output src_valid_i, src_waddr_i, src_wdata_i,
    input  src_ready_o, wb_we_o, wb_waddr_o, wb_wdata_o, wb_src_o, contention_o, busy_o
  );

  modport slave (
    input  src_valid_i, src_waddr_i, src_wdata_i,
    output src_ready_o, wb_we_o, wb_waddr_o, wb_wdata_o, wb_src_o, contention_o, busy_o
  );
endinterface

// File: rtl/riscv_wb_arbiter.sv
// Writeback arbiter: per-source FIFOs drained one entry per cycle onto a registered RF write port (2-edge latency).
// src_ready_o falls only when that source's FIFO is full; the write port itself never backpressures.
module riscv_wb_arbiter #(
  parameter int N_SRC      = 3,
  parameter int DEPTH      = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int RR_ARB     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  riscv_wb_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(N_SRC);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
  } entry_t;

  entry_t        mem_q    [N_SRC][DEPTH];
  entry_t        entry_in [N_SRC];
  logic [PW-1:0] wptr_q   [N_SRC];
  logic [PW-1:0] wptr_d   [N_SRC];
  logic [PW-1:0] rptr_q   [N_SRC];
  logic [PW-1:0] rptr_d   [N_SRC];
  logic [CW-1:0] cnt_q    [N_SRC];
  logic [CW-1:0] cnt_d    [N_SRC];

  logic [SW-1:0] rr_q, rr_d;
  logic          wb_we_q, wb_we_d;
  entry_t        wb_q, wb_d;
  logic [SW-1:0] wb_src_q, wb_src_d;
  logic          cont_q, cont_d;

  logic [N_SRC-1:0] nonempty;
  logic [N_SRC-1:0] ready;
  logic [N_SRC-1:0] push;
  logic [N_SRC-1:0] pop;
  logic             gnt_vld;
  logic [SW-1:0]    gnt_idx;

  // Ready is a pure function of the stored count so a full FIFO refuses a push even while it pops.
  always_comb begin : p_status
    for (int i = 0; i < N_SRC; i++) begin
      nonempty[i]       = (cnt_q[i] != '0);
      ready[i]          = (cnt_q[i] < CW'(DEPTH));
      push[i]           = bus.src_valid_i[i] & ready[i] & ~flush_i;
      entry_in[i].waddr = bus.src_waddr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
      entry_in[i].wdata = bus.src_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin : p_arb
    logic [SW:0]   sum;
    logic [SW-1:0] idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (RR_ARB != 0) begin
        sum = {1'b0, rr_q} + (SW+1)'(k);
        if (sum >= (SW+1)'(N_SRC)) begin
          sum = sum - (SW+1)'(N_SRC);
        end
      end else begin
        sum = (SW+1)'(k);
      end
      idx = sum[SW-1:0];
      if (!gnt_vld && nonempty[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
    for (int i = 0; i < N_SRC; i++) begin
      pop[i] = gnt_vld && (gnt_idx == SW'(i));
    end
  end

  always_comb begin : p_next
    for (int i = 0; i < N_SRC; i++) begin
      wptr_d[i] = wptr_q[i];
      rptr_d[i] = rptr_q[i];
      cnt_d[i]  = cnt_q[i];
      if (flush_i) begin
        wptr_d[i] = '0;
        rptr_d[i] = '0;
        cnt_d[i]  = '0;
      end else begin
        if (push[i]) wptr_d[i] = wptr_q[i] + 1'b1;
        if (pop[i])  rptr_d[i] = rptr_q[i] + 1'b1;
        cnt_d[i] = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
      end
    end

    rr_d     = rr_q;
    wb_we_d  = 1'b0;
    wb_d     = wb_q;
    wb_src_d = wb_src_q;
    cont_d   = 1'b0;
    // A flush drops buffered entries but leaves the round-robin position where it was.
    if (!flush_i) begin
      cont_d = ($countones(nonempty) > 1);
      if (gnt_vld) begin
        wb_we_d  = 1'b1;
        wb_d     = mem_q[gnt_idx][rptr_q[gnt_idx]];
        wb_src_d = gnt_idx;
        if (RR_ARB != 0) begin
          rr_d = (gnt_idx == SW'(N_SRC-1)) ? '0 : gnt_idx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SRC; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      rr_q     <= '0;
      wb_we_q  <= 1'b0;
      wb_q     <= '0;
      wb_src_q <= '0;
      cont_q   <= 1'b0;
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        wptr_q[i] <= wptr_d[i];
        rptr_q[i] <= rptr_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      rr_q     <= rr_d;
      wb_we_q  <= wb_we_d;
      wb_q     <= wb_d;
      wb_src_q <= wb_src_d;
      cont_q   <= cont_d;
    end
  end

  // Payload storage needs no reset: only slots covered by a nonzero count are ever read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_SRC; i++) begin
      if (push[i]) begin
        mem_q[i][wptr_q[i]] <= entry_in[i];
      end
    end
  end

  assign bus.src_ready_o  = ready;
  assign bus.wb_we_o      = wb_we_q;
  assign bus.wb_waddr_o   = wb_q.waddr;
  assign bus.wb_wdata_o   = wb_q.wdata;
  assign bus.wb_src_o     = wb_src_q;
  assign bus.contention_o = cont_q;
  assign bus.busy_o       = (|nonempty) | wb_we_q;

  for (genvar i = 0; i < N_SRC; i++) begin : g_chk
    a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n) cnt_q[i] <= CW'(DEPTH));
  end

endmodule
